// File: rtl/vls_sp_arbiter.sv
// Round-robin arbiter and sequencer for the single scratchpad access port.
// One command is accepted per grant; the scratchpad is driven until sp_dhit or timeout.
module vls_sp_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TO_CYC = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     sp_req,
  output logic                     sp_we,
  output logic [ADDR_W-1:0]        sp_addr,
  output logic [DATA_W-1:0]        sp_wdata,
  input  logic                     sp_dhit,
  input  logic [DATA_W-1:0]        sp_rdata,
  output logic                     busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0]   NREQ_W  = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_ID = IDX_W'(NREQ - 1);
  localparam logic [7:0]       TO_LAST = 8'(TO_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [7:0]          to_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [IDX_W-1:0]    lat_id;

  logic                gnt_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    rr_next;
  logic [ADDR_W-1:0]   addr_arr  [NREQ];
  logic [DATA_W-1:0]   wdata_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // First valid requester found scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    logic [IDX_W:0] sum;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!gnt_any && req_valid[sum[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign rr_next = (lat_id == LAST_ID) ? '0 : lat_id + IDX_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      to_cnt    <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            lat_we    <= req_we[gnt_idx];
            lat_addr  <= addr_arr[gnt_idx];
            lat_wdata <= wdata_arr[gnt_idx];
            lat_id    <= gnt_idx;
            to_cnt    <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A hit on the timeout cycle still completes as a success.
          if (sp_dhit) begin
            rsp_valid <= 1'b1;
            rsp_id    <= 3'(lat_id);
            rsp_rdata <= lat_we ? '0 : sp_rdata;
            rr_ptr    <= rr_next;
            state     <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_id    <= 3'(lat_id);
            rr_ptr    <= rr_next;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scratchpad side is driven only while BUSY so it reads zero otherwise.
  assign busy     = (state == BUSY);
  assign sp_req   = busy;
  assign sp_we    = busy & lat_we;
  assign sp_addr  = busy ? lat_addr  : '0;
  assign sp_wdata = busy ? lat_wdata : '0;

endmodule
